// File: rtl/cpri_tx_arb.sv
// Round-robin arbiter sharing the CPRI TX buffer write port among NUM_CH lanes.
// Sequences the granted lane's latency-1 buffer reads and forwards words as a write burst.
module cpri_tx_arb #(
  parameter int NUM_CH  = 4,
  parameter int BLK_LEN = 96,
  parameter int GAP_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_en,
  input  logic [NUM_CH-1:0]      i_req,
  input  logic [NUM_CH*64-1:0]   i_rd_data,
  output logic [NUM_CH-1:0]      o_rd_en,
  output logic [6:0]             o_rd_addr,
  output logic [NUM_CH-1:0]      o_done,
  output logic                   o_busy,
  output logic                   o_cpri_wen,
  output logic [6:0]             o_cpri_waddr,
  output logic [63:0]            o_cpri_wdata,
  output logic                   o_cpri_wlast,
  output logic [2:0]             o_cpri_chn
);

  localparam int GW = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);
  localparam logic [6:0] LAST_ADDR = 7'(BLK_LEN - 1);
  localparam logic [3:0] NUM_CH_4  = 4'(NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_GAP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_gnt;
  logic [2:0]          r_rr_ptr;
  logic [6:0]          r_cnt;
  logic [GW-1:0]       r_gap;

  logic                r_s1_vld;
  logic [6:0]          r_s1_addr;
  logic [2:0]          r_s1_gnt;
  logic                r_s1_last;

  logic                r_wen;
  logic [6:0]          r_waddr;
  logic [63:0]         r_wdata;
  logic                r_wlast;
  logic [2:0]          r_chn;
  logic [NUM_CH-1:0]   r_done;

  logic [NUM_CH-1:0]   w_rot;
  logic                w_found;
  logic [2:0]          w_off;
  logic [3:0]          w_sum;
  logic [2:0]          w_sel;
  logic [2:0]          w_ptr_nxt;
  logic [NUM_CH-1:0]   w_gnt_oh;
  logic [NUM_CH-1:0]   w_s1_gnt_oh;
  logic [63:0]         w_rd_word;
  logic                w_gnt_ld;
  logic                w_last_rd;
  logic [NUM_CH-1:0]   w_rd_en;
  logic [6:0]          w_rd_addr;

  // Rotate requests so bit 0 is the lane at rr_ptr; the lowest set bit wins.
  assign w_rot = NUM_CH'({i_req, i_req} >> r_rr_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_off   = 3'(i);
      end
    end
  end

  assign w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_sel     = (w_sum >= NUM_CH_4) ? 3'(w_sum - NUM_CH_4) : w_sum[2:0];
  assign w_ptr_nxt = (w_sel == 3'(NUM_CH - 1)) ? 3'd0 : w_sel + 3'd1;

  always_comb begin
    w_gnt_oh    = '0;
    w_s1_gnt_oh = '0;
    w_rd_word   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_gnt_oh[k]    = (r_gnt == 3'(k));
      w_s1_gnt_oh[k] = (r_s1_gnt == 3'(k));
      if (r_s1_gnt == 3'(k)) w_rd_word = i_rd_data[k*64 +: 64];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_ld    = 1'b0;
    w_last_rd   = 1'b0;
    w_rd_en     = '0;
    w_rd_addr   = '0;
    case (r_state)
      S_IDLE: begin
        if (i_en && w_found) begin
          w_gnt_ld    = 1'b1;
          w_state_nxt = S_RD;
        end
      end
      S_RD: begin
        w_rd_en   = w_gnt_oh;
        w_rd_addr = r_cnt;
        if (r_cnt == LAST_ADDR) begin
          w_last_rd   = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt     <= '0;
      r_rr_ptr  <= '0;
      r_cnt     <= '0;
      r_gap     <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_addr <= '0;
      r_s1_gnt  <= '0;
      r_s1_last <= 1'b0;
      r_wen     <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wlast   <= 1'b0;
      r_chn     <= '0;
      r_done    <= '0;
    end else begin
      if (w_gnt_ld) begin
        r_gnt    <= w_sel;
        r_rr_ptr <= w_ptr_nxt;
        r_cnt    <= '0;
      end else if (r_state == S_RD && !w_last_rd) begin
        r_cnt <= r_cnt + 7'd1;
      end

      if (w_last_rd)                          r_gap <= GW'(GAP_CYC - 1);
      else if (r_state == S_GAP && r_gap != '0) r_gap <= r_gap - 1'b1;

      // Stage 1: lane read data arrives while these are held.
      r_s1_vld  <= |w_rd_en;
      r_s1_addr <= w_rd_addr;
      r_s1_gnt  <= r_gnt;
      r_s1_last <= w_last_rd;

      // Stage 2: outputs are forced to zero outside a write.
      r_wen   <= r_s1_vld;
      r_waddr <= r_s1_vld ? r_s1_addr : '0;
      r_wdata <= r_s1_vld ? w_rd_word : '0;
      r_chn   <= r_s1_vld ? r_s1_gnt : '0;
      r_wlast <= r_s1_vld & r_s1_last;
      r_done  <= (r_s1_vld & r_s1_last) ? w_s1_gnt_oh : '0;
    end
  end

  assign o_rd_en      = w_rd_en;
  assign o_rd_addr    = w_rd_addr;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;
  assign o_cpri_wen   = r_wen;
  assign o_cpri_waddr = r_waddr;
  assign o_cpri_wdata = r_wdata;
  assign o_cpri_wlast = r_wlast;
  assign o_cpri_chn   = r_chn;

endmodule
